sl_transmitter: RTL and testbench



---
 rtl/sl_transmitter_if.sv | 13 +
 rtl/sl_transmitter.sv | 198 +++++++++++++++++++
 tb/tb_sl_transmitter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sl_transmitter_if.sv
// Word handshake between the register side (master) and the SL transmitter (slave).
interface sl_transmitter_if;
    logic [31:0] tx_data;
    logic [5:0]  tx_len;
    logic        tx_bad_parity;
    logic        tx_valid;
    logic        tx_ready;

    modport master (output tx_data, output tx_len, output tx_bad_parity, output tx_valid,
                    input  tx_ready);
    modport slave  (input  tx_data, input  tx_len, input  tx_bad_parity, input  tx_valid,
                    output tx_ready);
endinterface

// File: rtl/sl_transmitter.sv
// SL word transmitter: serialises a word LSB-first on the active-low sl0/sl1 lines,
// followed by an odd-parity symbol and a stop symbol (both lines low).
module sl_transmitter #(
    parameter int LOW_CYCLES  = 16,
    parameter int HIGH_CYCLES = 16,
    parameter int MIN_LEN     = 8,
    parameter int MAX_LEN     = 32
) (
    input  logic               clk,
    input  logic               rst,
    sl_transmitter_if.slave    tx,
    output logic               sl0,
    output logic               sl1,
    output logic               busy,
    output logic               done,
    output logic               len_err
);
    localparam int PH_MAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int CNT_W  = $clog2(PH_MAX);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYM_LOW  = 2'd1,
        SYM_HIGH = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Parity symbol value making the count of ones over data+P odd.
    function automatic logic odd_parity_bit(input logic [31:0] data, input logic [5:0] len);
        logic ones;
        ones = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (6'(i) < len) begin
                ones = ones ^ data[i];
            end else begin
                ones = ones;
            end
        end
        return ~ones;
    endfunction

    // Line levels {sl0, sl1} while symbol idx is being driven low.
    function automatic logic [1:0] sym_lines(input logic [5:0] idx, input logic [5:0] len,
                                             input logic dbit, input logic par);
        logic [1:0] lines;
        if (idx < len) begin
            lines = {dbit, ~dbit};
        end else if (idx == len) begin
            lines = {par, ~par};
        end else begin
            lines = 2'b00;
        end
        return lines;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [5:0]       len_q, len_d;
    logic [31:0]      shift_q, shift_d;
    logic             par_q, par_d;
    logic             sl0_q, sl0_d;
    logic             sl1_q, sl1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             len_err_q, len_err_d;
    logic             tx_ready_q, tx_ready_d;
    logic             len_bad_s;
    logic [1:0]       lines_s;

    assign len_bad_s = (tx.tx_len < 6'(MIN_LEN)) || (tx.tx_len > 6'(MAX_LEN));

    // Next-state and next-output computation for the symbol sequencer.
    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        par_d      = par_q;
        sl0_d      = sl0_q;
        sl1_d      = sl1_q;
        busy_d     = busy_q;
        tx_ready_d = tx_ready_q;
        done_d     = 1'b0;
        len_err_d  = 1'b0;
        lines_s    = 2'b11;
        case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                if (tx.tx_valid && tx_ready_q) begin
                    if (len_bad_s) begin
                        len_err_d = 1'b1;
                    end else begin
                        shift_d    = tx.tx_data;
                        len_d      = tx.tx_len;
                        par_d      = odd_parity_bit(tx.tx_data, tx.tx_len) ^ tx.tx_bad_parity;
                        bit_cnt_d  = 6'd0;
                        cyc_cnt_d  = '0;
                        lines_s    = sym_lines(6'd0, tx.tx_len, tx.tx_data[0], par_d);
                        sl0_d      = lines_s[1];
                        sl1_d      = lines_s[0];
                        busy_d     = 1'b1;
                        tx_ready_d = 1'b0;
                        state_d    = SYM_LOW;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SYM_LOW: begin
                if (cyc_cnt_q == LOW_LAST) begin
                    cyc_cnt_d = '0;
                    sl0_d     = 1'b1;
                    sl1_d     = 1'b1;
                    state_d   = SYM_HIGH;
                    if (bit_cnt_q < len_q) begin
                        shift_d = {1'b0, shift_q[31:1]};
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end
            SYM_HIGH: begin
                if (cyc_cnt_q == HIGH_LAST) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == len_q + 6'd1) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // shift_q[0] already holds the next data bit after the shift in SYM_LOW.
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        lines_s   = sym_lines(bit_cnt_q + 6'd1, len_q, shift_q[0], par_q);
                        sl0_d     = lines_s[1];
                        sl1_d     = lines_s[0];
                        state_d   = SYM_LOW;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                tx_ready_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                sl0_d      = 1'b1;
                sl1_d      = 1'b1;
                busy_d     = 1'b0;
                tx_ready_d = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    // State, counter and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_cnt_q  <= '0;
            bit_cnt_q  <= 6'd0;
            len_q      <= 6'd0;
            shift_q    <= 32'd0;
            par_q      <= 1'b0;
            sl0_q      <= 1'b1;
            sl1_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            sl0_q      <= sl0_d;
            sl1_q      <= sl1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_err_q  <= len_err_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign sl0         = sl0_q;
    assign sl1         = sl1_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign len_err     = len_err_q;
    assign tx.tx_ready = tx_ready_q;
endmodule

// File: tb/tb_sl_transmitter.sv
// Bench for sl_transmitter: every cycle's outputs are compared against a timeline model
// derived from the accepted word (symbol index and phase by plain arithmetic).
module tb_sl_transmitter;
    localparam int LOW  = 16;
    localparam int HIGH = 16;
    localparam int SP   = LOW + HIGH;

    logic clk = 1'b0;
    logic rst;
    logic sl0, sl1, busy, done, len_err;

    sl_transmitter_if tx_if ();

    sl_transmitter #(.LOW_CYCLES(LOW), .HIGH_CYCLES(HIGH), .MIN_LEN(8), .MAX_LEN(32)) dut (
        .clk(clk), .rst(rst), .tx(tx_if),
        .sl0(sl0), .sl1(sl1), .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: cycle index of the last edge, the accepted word and its start.
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          lerr_cyc = -10;
    int          n_acc    = 0;
    bit          m_act    = 1'b0;
    bit          chk_on   = 1'b0;
    int          m_len    = 0;
    logic [31:0] m_data   = 32'd0;
    bit          m_bad    = 1'b0;

    function automatic int m_dur();
        return (m_len + 2) * SP;
    endfunction

    function automatic bit m_ready();
        if (!m_act) return 1'b1;
        return (cyc - acc_cyc + 1) > (m_dur() + 1);
    endfunction

    // Expected {sl0, sl1, busy, done, len_err, tx_ready} for the current cycle.
    function automatic logic [5:0] m_exp();
        logic l0, l1, b, d, r;
        int   k, s, ones;
        bit   v;
        l0 = 1'b1; l1 = 1'b1; b = 1'b0; d = 1'b0; r = 1'b1;
        if (m_act) begin
            k = cyc - acc_cyc + 1;
            if (k <= m_dur()) begin
                b = 1'b1;
                r = 1'b0;
                s = (k - 1) / SP;
                if (((k - 1) % SP) < LOW) begin
                    if (s == m_len + 1) begin
                        l0 = 1'b0;
                        l1 = 1'b0;
                    end else begin
                        if (s < m_len) begin
                            v = m_data[s];
                        end else begin
                            ones = 0;
                            for (int i = 0; i < m_len; i++) ones += int'(m_data[i]);
                            v = ((ones % 2) == 0) ^ m_bad;
                        end
                        l0 = v;
                        l1 = !v;
                    end
                end
            end else if (k == m_dur() + 1) begin
                d = 1'b1;
                r = 1'b0;
            end
        end
        return {l0, l1, b, d, (cyc == lerr_cyc), r};
    endfunction

    // Model update on each rising edge using the inputs the DUT samples there.
    always @(posedge clk) begin
        if (rst) begin
            m_act    = 1'b0;
            lerr_cyc = -10;
            chk_on   = 1'b1;
        end else if (tx_if.tx_valid && m_ready()) begin
            if (tx_if.tx_len >= 8 && tx_if.tx_len <= 32) begin
                m_act   = 1'b1;
                acc_cyc = cyc + 1;
                m_len   = int'(tx_if.tx_len);
                m_data  = tx_if.tx_data;
                m_bad   = tx_if.tx_bad_parity;
            end else begin
                lerr_cyc = cyc + 1;
            end
            n_acc++;
        end
        cyc++;
    end

    // Per-cycle output comparison away from the active edge.
    always @(negedge clk) begin
        logic [5:0] e;
        if (chk_on) begin
            e = m_exp();
            chk_eq("lines",    {30'd0, sl0, sl1},   {30'd0, e[5:4]});
            chk_eq("busy",     {31'd0, busy},       {31'd0, e[3]});
            chk_eq("done",     {31'd0, done},       {31'd0, e[2]});
            chk_eq("len_err",  {31'd0, len_err},    {31'd0, e[1]});
            chk_eq("tx_ready", {31'd0, tx_if.tx_ready}, {31'd0, e[0]});
        end
    end

    task automatic scramble_inputs();
        tx_if.tx_valid      = 1'b0;
        tx_if.tx_data       = $urandom;
        tx_if.tx_len        = 6'($urandom);
        tx_if.tx_bad_parity = 1'($urandom);
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] l, input bit bad, input bit hold);
        int start;
        int guard;
        @(negedge clk);
        tx_if.tx_data       = d;
        tx_if.tx_len        = l;
        tx_if.tx_bad_parity = bad;
        tx_if.tx_valid      = 1'b1;
        start = n_acc;
        guard = 0;
        while (n_acc == start && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_eq("accepted", n_acc - start, 32'd1);
        if (!hold) begin
            @(negedge clk);
            scramble_inputs();
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!m_ready() && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_eq("idle_reached", {31'd0, m_ready()}, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        send(32'h0000_00A5, 6'd8, 1'b0, 1'b0);
        wait_idle();
        send(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
        wait_idle();
        send(32'h0000_0055, 6'd7, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        send(32'h0000_0055, 6'd33, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        send(32'h0000_000F, 6'd8, 1'b1, 1'b0);
        wait_idle();

        send(32'h0000_00A5, 6'd8, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(32'h0000_003C, 6'd8, 1'b0, 1'b0);
        wait_idle();

        send(32'h0000_0012, 6'd8, 1'b0, 1'b1);
        send(32'h0000_0034, 6'd8, 1'b0, 1'b0);
        wait_idle();

        for (int n = 0; n < 24; n++) begin
            logic [5:0] l;
            l = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(8, 32));
            send($urandom, l, 1'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
